// File: rtl/vr_pkg.sv
// Shared definitions for the valid/ready pipeline: register-style selectors,
// per-stage state encoding and a helper that maps a state to its beat count.
package vr_pkg;

  localparam int VR_MODE_BYPASS = 0;
  localparam int VR_MODE_FWD    = 1;
  localparam int VR_MODE_FULL   = 2;

  typedef enum logic [1:0] {
    VR_EMPTY = 2'd0,
    VR_MAIN  = 2'd1,
    VR_FULL  = 2'd2
  } vr_state_e;

  function automatic logic [1:0] vr_count(vr_state_e s);
    case (s)
      VR_MAIN: return 2'd1;
      VR_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vr_slice.sv
// One valid/ready register stage. MODE 1 holds a single beat with a
// combinational ready path; MODE 2 adds a skid register so ready is registered.
module vr_slice
  import vr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = VR_MODE_FULL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  vr_state_e        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             drain;

  assign accept = in_valid_i & in_ready_o;
  assign drain  = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VR_EMPTY;
    end else begin
      state_q <= state_d;
    end
    main_q <= main_d;
    skid_q <= skid_d;
  end

  // Forward mode never reaches FULL: in MAIN it only accepts while draining.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      VR_EMPTY: begin
        if (accept) begin
          state_d = VR_MAIN;
          main_d  = in_data_i;
        end
      end
      VR_MAIN: begin
        if (accept && drain) begin
          main_d = in_data_i;
        end else if (accept) begin
          state_d = VR_FULL;
          skid_d  = in_data_i;
        end else if (drain) begin
          state_d = VR_EMPTY;
        end
      end
      VR_FULL: begin
        if (drain) begin
          state_d = VR_MAIN;
          main_d  = skid_q;
        end
      end
      default: state_d = VR_EMPTY;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q != VR_EMPTY);
    out_data_o  = main_q;
    count_o     = vr_count(state_q);
    if (rst) begin
      in_ready_o = 1'b0;
    end else if (MODE == VR_MODE_FWD) begin
      in_ready_o = (state_q == VR_EMPTY) || out_ready_i;
    end else begin
      in_ready_o = (state_q != VR_FULL);
    end
  end

endmodule

// File: rtl/valid_ready_pipe.sv
// Chain of DEPTH valid/ready stages (or plain wires in bypass mode) with a
// running sum of the per-stage beat counts exported as occupancy.
module valid_ready_pipe
  import vr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int MODE  = VR_MODE_FULL
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [WIDTH-1:0]                data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [WIDTH-1:0]                data_o,
  output logic [$clog2(2*DEPTH+2)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(2*DEPTH+2);

  if (DEPTH < 1 || MODE < VR_MODE_BYPASS || MODE > VR_MODE_FULL) begin : g_bad_params
    $error("valid_ready_pipe: illegal parameters DEPTH=%0d MODE=%0d", DEPTH, MODE);
  end

  if (MODE == VR_MODE_BYPASS) begin : g_bypass
    logic unused_bypass;
    assign valid_o       = valid_i;
    assign data_o        = data_i;
    assign ready_o       = ready_i;
    assign occupancy     = '0;
    assign unused_bypass = clk ^ rst;
  end else begin : g_pipe
    // Each stage links to its neighbours by name so the ready chain has no
    // self-referencing vector.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             in_valid;
      logic             in_ready;
      logic [WIDTH-1:0] in_data;
      logic             out_valid;
      logic             out_ready;
      logic [WIDTH-1:0] out_data;
      logic [1:0]       count;
      logic [OCC_W-1:0] count_sum;

      if (gi == 0) begin : g_head
        assign in_valid  = valid_i;
        assign in_data   = data_i;
        assign count_sum = OCC_W'(count);
      end else begin : g_link
        assign in_valid  = g_stage[gi-1].out_valid;
        assign in_data   = g_stage[gi-1].out_data;
        assign count_sum = g_stage[gi-1].count_sum + OCC_W'(count);
      end

      if (gi == DEPTH - 1) begin : g_tail
        assign out_ready = ready_i;
      end else begin : g_mid
        assign out_ready = g_stage[gi+1].in_ready;
      end

      vr_slice #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
      ) u_slice (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .count_o     (count)
      );
    end

    assign ready_o   = g_stage[0].in_ready;
    assign valid_o   = g_stage[DEPTH-1].out_valid;
    assign data_o    = g_stage[DEPTH-1].out_data;
    assign occupancy = g_stage[DEPTH-1].count_sum;
  end

endmodule

// File: tb/tb_valid_ready_pipe.sv
// Drives four pipe configurations side by side and checks them against a
// beat-queue model: every accepted beat must leave once, in order, intact.
module tb_valid_ready_pipe;

  localparam int W     = 16;
  localparam int NL    = 4;
  localparam int LMODE  [NL] = '{2, 2, 1, 0};
  localparam int LDEPTH [NL] = '{2, 1, 3, 1};

  logic          clk = 1'b0;
  logic          rst;
  logic [NL-1:0] valid_i;
  logic [NL-1:0] ready_o;
  logic [W-1:0]  data_i [NL];
  logic [NL-1:0] valid_o;
  logic [NL-1:0] ready_i;
  logic [W-1:0]  data_o [NL];
  logic [3:0]    occ_a  [NL];

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  bit verbose  = 1'b1;

  logic [W-1:0] sb [NL][256];
  int           wr [NL];
  int           rd [NL];
  bit           stall_q [NL];
  logic [W-1:0] hold_q  [NL];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    localparam int M = LMODE[gi];
    localparam int D = LDEPTH[gi];
    logic [$clog2(2*D+2)-1:0] occ_l;

    valid_ready_pipe #(
      .WIDTH (W),
      .DEPTH (D),
      .MODE  (M)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_i[gi]),
      .ready_o   (ready_o[gi]),
      .data_i    (data_i[gi]),
      .valid_o   (valid_o[gi]),
      .ready_i   (ready_i[gi]),
      .data_o    (data_o[gi]),
      .occupancy (occ_l)
    );
    assign occ_a[gi] = 4'(occ_l);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_cap(int l);
    if (LMODE[l] == 2) return 2 * LDEPTH[l];
    if (LMODE[l] == 1) return LDEPTH[l];
    return 0;
  endfunction

  // Reference model: a FIFO of accepted beats per lane, sampled mid-cycle.
  initial begin
    for (int l = 0; l < NL; l++) begin
      wr[l] = 0; rd[l] = 0; stall_q[l] = 1'b0; hold_q[l] = '0;
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int l = 0; l < NL; l++) begin
          int cnt;
          cnt = wr[l] - rd[l];
          check($sformatf("occupancy[%0d]", l), 32'(occ_a[l]), cnt);
          if (LMODE[l] != 0) begin
            check($sformatf("occ_bound[%0d]", l), 32'(cnt <= lane_cap(l)), 1);
            if (rst) check($sformatf("rst_ready[%0d]", l), 32'(ready_o[l]), 0);
            if (stall_q[l]) begin
              check($sformatf("stall_valid[%0d]", l), 32'(valid_o[l]), 1);
              check($sformatf("stall_data[%0d]", l), 32'(data_o[l]), 32'(hold_q[l]));
            end
            stall_q[l] = valid_o[l] && !ready_i[l] && !rst;
            hold_q[l]  = data_o[l];
          end
          if (valid_i[l] && ready_o[l]) begin
            sb[l][wr[l] % 256] = data_i[l];
            wr[l]++;
          end
          if (valid_o[l] && ready_i[l]) begin
            if (verbose) $display("beat lane%0d data=0x%0h", l, data_o[l]);
            if (wr[l] == rd[l]) begin
              check($sformatf("spurious_beat[%0d]", l), 32'(valid_o[l]), 0);
            end else begin
              check($sformatf("beat_data[%0d]", l), 32'(data_o[l]), 32'(sb[l][rd[l] % 256]));
              rd[l]++;
            end
          end
          if (rst) rd[l] = wr[l];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int k, n_out, first_acc, first_out, last_out;

    // Reset held with valid_i high on every lane.
    rst = 1'b1; valid_i = '1; ready_i = '0;
    for (int l = 0; l < NL; l++) data_i[l] = W'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        check("rst_valid_o", 32'(valid_o[l]), 0);
        check("rst_ready_o", 32'(ready_o[l]), 0);
        check("rst_occupancy", 32'(occ_a[l]), 0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; valid_i = '0; mon_en = 1'b1;
    @(negedge clk);
    for (int l = 0; l < 3; l++) check("post_rst_ready_o", 32'(ready_o[l]), 1);
    @(posedge clk); #1;

    // Lane 0 (full, depth 2): 13 back-to-back beats with ready_i held high.
    ready_i[0] = 1'b1; k = 0; n_out = 0; first_acc = -1; first_out = -1; last_out = 0;
    for (int t = 0; t < 40; t++) begin
      valid_i[0] = (k < 13); data_i[0] = W'(k);
      @(negedge clk);
      if (valid_i[0] && ready_o[0]) begin
        if (first_acc < 0) first_acc = t;
        k++;
      end
      if (valid_o[0]) begin
        if (first_out < 0) first_out = t;
        check("stream_data", 32'(data_o[0]), n_out);
        n_out++; last_out = t;
      end
      @(posedge clk); #1;
    end
    check("stream_latency", first_out - first_acc, LDEPTH[0]);
    check("stream_count", n_out, 13);
    check("stream_span", last_out - first_out, 12);

    // Lane 1 (full, depth 1): two beats under backpressure fill both registers.
    ready_i[1] = 1'b0; k = 0;
    for (int t = 0; t < 6; t++) begin
      valid_i[1] = 1'b1;
      data_i[1]  = (k == 0) ? W'(16'hA) : (k == 1) ? W'(16'hB) : W'(16'hC);
      @(negedge clk);
      if (valid_i[1] && ready_o[1]) k++;
      if (t == 5) begin
        check("bp_accepts", k, 2);
        check("bp_ready_o", 32'(ready_o[1]), 0);
        check("bp_occupancy", 32'(occ_a[1]), 2);
      end
      @(posedge clk); #1;
    end
    valid_i[1] = 1'b0; ready_i[1] = 1'b1; n_out = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (valid_o[1]) begin
        check("bp_data", 32'(data_o[1]), (n_out == 0) ? 32'hA : 32'hB);
        n_out++;
      end
      @(posedge clk); #1;
    end
    check("bp_count", n_out, 2);

    // Lane 2 (forward, depth 3): continuous valid, ready toggling each cycle.
    k = 0; n_out = 0;
    for (int t = 0; t < 80 && n_out < 13; t++) begin
      valid_i[2] = (k < 13); data_i[2] = W'(k); ready_i[2] = (t % 2 == 0);
      @(negedge clk);
      if (valid_i[2] && ready_o[2]) k++;
      if (valid_o[2] && ready_i[2]) begin
        check("alt_data", 32'(data_o[2]), n_out);
        n_out++;
      end
      @(posedge clk); #1;
    end
    valid_i[2] = 1'b0;
    check("alt_count", n_out, 13);

    // Lane 2: fill to three beats, reset mid-stream, then a lone 0x55.
    ready_i[2] = 1'b0; k = 0;
    for (int t = 0; t < 10; t++) begin
      valid_i[2] = (k < 3); data_i[2] = W'(16'h30 + k);
      @(negedge clk);
      if (valid_i[2] && ready_o[2]) k++;
      @(posedge clk); #1;
    end
    valid_i[2] = 1'b0;
    @(negedge clk);
    check("mid_occupancy", 32'(occ_a[2]), 3);
    check("mid_ready_o", 32'(ready_o[2]), 0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid_o", 32'(valid_o[2]), 0);
    check("mid_rst_occupancy", 32'(occ_a[2]), 0);
    @(posedge clk); #1;
    valid_i[2] = 1'b1; data_i[2] = W'(16'h55); ready_i[2] = 1'b1;
    @(negedge clk);
    check("post_rst_accept", 32'(ready_o[2]), 1);
    @(posedge clk); #1;
    valid_i[2] = 1'b0; n_out = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (valid_o[2]) begin
        check("post_rst_data", 32'(data_o[2]), 32'h55);
        n_out++;
      end
      @(posedge clk); #1;
    end
    check("post_rst_count", n_out, 1);

    // Lane 3 (bypass): outputs follow inputs within the same cycle.
    for (int t = 0; t < 8; t++) begin
      valid_i[3] = 1'($urandom); ready_i[3] = 1'($urandom); data_i[3] = W'($urandom);
      #1;
      check("byp_valid_o", 32'(valid_o[3]), 32'(valid_i[3]));
      check("byp_ready_o", 32'(ready_o[3]), 32'(ready_i[3]));
      check("byp_data_o", 32'(data_o[3]), 32'(data_i[3]));
      check("byp_occupancy", 32'(occ_a[3]), 0);
      @(posedge clk); #1;
    end

    // Random traffic on all lanes with occasional resets.
    verbose = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      for (int l = 0; l < NL; l++) begin
        valid_i[l] = ($urandom_range(0, 3) != 0);
        ready_i[l] = ($urandom_range(0, 2) != 0);
        data_i[l]  = W'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; valid_i = '0; ready_i = '1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      check("drain_occupancy", 32'(occ_a[l]), 0);
      check("drain_valid_o", 32'(valid_o[l]), 0);
      check("drain_model_empty", wr[l] - rd[l], 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
